ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares one RAM_SINGLE_READ_PORT instance between two requesters: port 0 (instruction fetch) and port 1 (data/RPG path).
//  Each access takes one cycle. Reads return one cycle after grant.
//  Arbitration is round-robin. A lock lets a requester hold the RAM for read-modify-write sequences.
//  Sits between the fetch/data units and the RAM. Drives the RAM's write enable, addresses and data-in.
// PARAMETERS
//  DATA_WIDTH  8   RAM word width
//  ADDR_WIDTH  10  RAM address width
//  LOCK_MAX    4   max consecutive locked grants before forced release (>=1)
// PORTS
//  Clock            in   1           clock, rising edge
//  Reset            in   1           asynchronous, active-low reset
//  iReq[1:0]        in   2           access request, one bit per port
//  iWe[1:0]         in   2           1=write, 0=read, per port
//  iLock[1:0]       in   2           hold ownership after this grant, per port
//  iAddr0/iAddr1    in   ADDR_WIDTH  per-port address
//  iData0/iData1    in   DATA_WIDTH  per-port write data
//  oGrant[1:0]      out  2           one-hot: port's access issued this cycle
//  oRdValid[1:0]    out  2           read data valid for that port
//  oRdData          out  DATA_WIDTH  read data, shared; qualified by oRdValid
//  oRamWriteEnable  out  1           to RAM iWriteEnable
//  oRamReadAddress  out  ADDR_WIDTH  to RAM iReadAddress
//  oRamWriteAddress out  ADDR_WIDTH  to RAM iWriteAddress
//  oRamDataIn       out  DATA_WIDTH  to RAM iDataIn
//  iRamDataOut      in   DATA_WIDTH  from RAM oDataOut
// BEHAVIOUR
//  - Reset (Reset=0, async):
//    - state=ARB; last-served pointer=1, so port 0 wins the first tie; lock counter=0.
//    - oRdValid=0 and the pending-read tag is cleared.
//    - Combinational outputs are 0 while in reset.
//  - oGrant, oRamWriteEnable, oRamReadAddress, oRamWriteAddress and oRamDataIn are combinational from state, iReq and the winner's inputs.
//  - A grant is a completed transfer. There is no stall and no multi-cycle hold.
//  - Both RAM addresses are driven with the winner's iAddr.
//  - oRamWriteEnable = winner's iWe. oRamDataIn = winner's iData. All four RAM outputs are 0 when there is no grant.
//  - Read latency is 1.
//    - A read granted in cycle N sets oRdValid[p]=1 in cycle N+1 for exactly one cycle.
//    - oRdData = iRamDataOut (passthrough). A registered 2-bit tag selects the valid bit.
//    - Back-to-back reads from alternating ports give valid on alternating ports with no gap.
//  - FSM states: ARB, LOCK0, LOCK1.
//    - ARB, single requester: grant it.
//    - ARB, both requesting: grant the port not served last, then update the pointer.
//    - ARB, granted port has iLock=1: go to LOCKp and set lock counter=1.
//    - LOCKp:
//      - Only port p can be granted. The other port's iReq is ignored and it receives no grant.
//      - On a grant to p with iLock=1 and counter<LOCK_MAX: stay and increment the counter.
//      - Release to ARB when any of these holds:
//        - p drops iReq (no grant that cycle);
//        - p is granted with iLock=0;
//        - counter==LOCK_MAX at a grant (forced release; that grant still issues).
//      - After a forced release, the pointer makes the other port win the next tie.
//  - The write/read same-address bypass is handled by the RAM. The arbiter does not modify it.
//  - Reset mid-access: an in-flight read is discarded and no oRdValid pulse is produced after reset deasserts.
//  - Grants are never both 1. oRdValid bits are never both 1.
// STRUCTURE
//  - Shared package:
//    - FSM state encoding: ARB=2'd0, LOCK0=2'd1, LOCK1=2'd2;
//    - port index constants PORT_FETCH=0, PORT_DATA=1.
//  - One natural sub-module: rr_pick2.
//    - Combinational 2-way round-robin picker.
//    - Inputs: req[1:0], last. Outputs: one-hot gnt.
//  - Remainder: FSM, lock counter ($clog2(LOCK_MAX+1) bits), read tag register, output muxing.
// TESTING
//  1. Reset, then port 0 alone reads addr 5 (preloaded 0xA5):
//     -> oGrant=01, RAM read addr 5; next cycle oRdValid=01, oRdData=0xA5.
//  2. Both ports request reads every cycle for 4 cycles:
//     -> grants 01,10,01,10; oRdValid follows one cycle later in the same order.
//  3. Port 1 writes 0x3C to addr 7 while port 0 is idle; then port 0 reads addr 7:
//     -> oRamWriteEnable=1 for one cycle; the read returns 0x3C.
//  4. Port 1 holds iLock=1 and iReq=1 with port 0 also requesting, LOCK_MAX=4:
//     -> four consecutive grants to port 1, then port 0 is granted.
//  5. Port 0 locks, then drops iReq the next cycle:
//     -> return to ARB; port 1 is granted that same cycle if it is requesting.
//  6. Assert Reset the cycle after a read grant:
//     -> no oRdValid pulse; all outputs 0; the first grant after release goes to port 0.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// State encoding and port indices used by the arbiter and its picker.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  localparam int PORT_FETCH = 0;
  localparam int PORT_DATA  = 1;

endpackage

// File: rtl/ram_port_arbiter_rr_pick2.sv
// Two-way round-robin picker.
// The port not served last wins a tie.
module rr_pick2
  import ram_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = last ? 2'b01 : 2'b10;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-read-port RAM between fetch and data ports.
// Round-robin arbitration with bounded lock for read-modify-write.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int LOCK_MAX   = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [1:0]            iReq,
  input  logic [1:0]            iWe,
  input  logic [1:0]            iLock,
  input  logic [ADDR_WIDTH-1:0] iAddr0,
  input  logic [ADDR_WIDTH-1:0] iAddr1,
  input  logic [DATA_WIDTH-1:0] iData0,
  input  logic [DATA_WIDTH-1:0] iData1,
  output logic [1:0]            oGrant,
  output logic [1:0]            oRdValid,
  output logic [DATA_WIDTH-1:0] oRdData,
  output logic                  oRamWriteEnable,
  output logic [ADDR_WIDTH-1:0] oRamReadAddress,
  output logic [ADDR_WIDTH-1:0] oRamWriteAddress,
  output logic [DATA_WIDTH-1:0] oRamDataIn,
  input  logic [DATA_WIDTH-1:0] iRamDataOut
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic [1:0]      tag_q, tag_d;
  logic [1:0]      rr_gnt;
  logic [1:0]      gnt;
  logic            locked;
  logic            win;
  logic            any;

  rr_pick2 u_pick (
    .req  (iReq),
    .last (last_q),
    .gnt  (rr_gnt)
  );

  // Owner dropping its request falls straight through to arbitration.
  always_comb begin
    locked = (state_q == LOCK0 && iReq[PORT_FETCH])
          || (state_q == LOCK1 && iReq[PORT_DATA]);
    gnt = 2'b00;
    if (Reset) begin
      if (locked)
        gnt = (state_q == LOCK1) ? 2'b10 : 2'b01;
      else
        gnt = rr_gnt;
    end
    win = gnt[PORT_DATA];
    any = |gnt;
  end

  always_comb begin
    state_d = ARB;
    cnt_d   = '0;
    last_d  = last_q;
    cnt_inc = cnt_q + CW'(1);
    tag_d   = gnt & ~iWe;
    if (any) begin
      last_d = win;
      if (locked) begin
        if (iLock[win] && cnt_inc < CW'(LOCK_MAX)) begin
          state_d = state_q;
          cnt_d   = cnt_inc;
        end
      end else if (iLock[win] && LOCK_MAX > 1) begin
        state_d = win ? LOCK1 : LOCK0;
        cnt_d   = CW'(1);
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ARB;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      tag_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    oGrant           = gnt;
    oRdValid         = tag_q;
    oRdData          = Reset ? iRamDataOut : '0;
    oRamWriteEnable  = any & iWe[win];
    oRamReadAddress  = '0;
    oRamWriteAddress = '0;
    oRamDataIn       = '0;
    if (any) begin
      oRamReadAddress  = win ? iAddr1 : iAddr0;
      oRamWriteAddress = win ? iAddr1 : iAddr0;
      oRamDataIn       = win ? iData1 : iData0;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM model, ownership model, directed tests.
module tb_ram_port_arbiter;

  localparam int LMAX = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, we, lock;
  logic [9:0] a0, a1;
  logic [7:0] d0, d1;
  logic [1:0] oGrant, oRdValid;
  logic [7:0] oRdData, oRamDataIn, ram_dout;
  logic       oRamWriteEnable;
  logic [9:0] oRamReadAddress, oRamWriteAddress;

  logic [7:0] mem [1024];

  int n_tests = 0;
  int n_fail  = 0;

  ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .LOCK_MAX(LMAX)) dut (
    .Clock(clk), .Reset(rst_n), .iReq(req), .iWe(we), .iLock(lock),
    .iAddr0(a0), .iAddr1(a1), .iData0(d0), .iData1(d1),
    .oGrant(oGrant), .oRdValid(oRdValid), .oRdData(oRdData),
    .oRamWriteEnable(oRamWriteEnable), .oRamReadAddress(oRamReadAddress),
    .oRamWriteAddress(oRamWriteAddress), .oRamDataIn(oRamDataIn),
    .iRamDataOut(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (oRamWriteEnable) mem[oRamWriteAddress] <= oRamDataIn;
    ram_dout <= mem[oRamReadAddress];
  end

  // Model: who owns the RAM, how many locked grants, who was served last.
  int         m_owner = -1, m_cnt = 0, m_last = 1, m_pend = -1;
  int         n_owner = -1, n_cnt = 0, n_last = 1, n_pend = -1;
  logic [7:0] m_pdata = 8'h00, n_pdata = 8'h00;

  always @(negedge clk) begin : cmp
    int own, w, c;
    logic [1:0] eg, ev;
    logic ewe;
    logic [9:0] ea;
    logic [7:0] ed;
    eg = 2'b00; ewe = 1'b0; ea = '0; ed = '0; w = -1;
    ev = (m_pend == 1) ? 2'b10 : (m_pend == 0) ? 2'b01 : 2'b00;
    n_owner = -1; n_cnt = 0; n_last = m_last; n_pend = -1; n_pdata = m_pdata;
    if (rst_n) begin
      own = m_owner;
      if (own >= 0 && !req[own]) own = -1;
      if (own >= 0) w = own;
      else if (req == 2'b11) w = 1 - m_last;
      else if (req[0]) w = 0;
      else if (req[1]) w = 1;
      if (w >= 0) begin
        eg  = (w == 1) ? 2'b10 : 2'b01;
        ewe = we[w];
        ea  = (w == 1) ? a1 : a0;
        ed  = (w == 1) ? d1 : d0;
        n_last = w;
        c = (own >= 0) ? m_cnt + 1 : 1;
        if (lock[w] && c < LMAX) begin n_owner = w; n_cnt = c; end
        if (!ewe) begin n_pend = w; n_pdata = mem[ea]; end
      end
    end else begin
      ev = 2'b00;
      n_last = 1;
    end
    n_tests++;
    if ({oGrant, oRdValid, oRamWriteEnable, oRamReadAddress, oRamWriteAddress, oRamDataIn}
        !== {eg, ev, ewe, ea, ea, ed}) begin
      n_fail++;
      $display("FAIL model t=%0t gnt=%b/%b vld=%b/%b we=%b/%b ra=%0d wa=%0d/%0d din=%h/%h",
               $time, oGrant, eg, oRdValid, ev, oRamWriteEnable, ewe,
               oRamReadAddress, oRamWriteAddress, ea, oRamDataIn, ed);
    end
    if (ev != 2'b00) begin
      n_tests++;
      if (oRdData !== m_pdata) begin
        n_fail++;
        $display("FAIL rddata t=%0t got=%h exp=%h", $time, oRdData, m_pdata);
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1; m_cnt <= 0; m_last <= 1; m_pend <= -1;
    end else begin
      m_owner <= n_owner; m_cnt <= n_cnt; m_last <= n_last;
      m_pend <= n_pend; m_pdata <= n_pdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                       input logic [9:0] x0, input logic [9:0] x1,
                       input logic [7:0] y0, input logic [7:0] y1);
    req = r; we = w; lock = l; a0 = x0; a1 = x1; d0 = y0; d1 = y1;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [1:0] gs [6];
  logic [1:0] vs [6];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[5] = 8'hA5;
    mem[6] = 8'h66;
    ram_dout = 8'h00;
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    step();
    rst_n = 1'b1;

    // 1: single read
    do_reset();
    drive(2'b01, 2'b00, 2'b00, 10'd5, 10'd0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t1_grant", 32'(oGrant), 32'h1);
    chk("t1_raddr", 32'(oRamReadAddress), 32'd5);
    step(); idle();
    @(negedge clk);
    chk("t1_valid", 32'(oRdValid), 32'h1);
    chk("t1_data", 32'(oRdData), 32'hA5);

    // 2: both reading, alternating
    do_reset();
    drive(2'b11, 2'b00, 2'b00, 10'd5, 10'd6, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      gs[i] = oGrant; vs[i] = oRdValid;
      step();
      if (i == 3) idle();
    end
    chk("t2_grants", 32'({gs[0], gs[1], gs[2], gs[3]}), 32'b01100110);
    chk("t2_valids", 32'({vs[1], vs[2], vs[3], vs[4]}), 32'b01100110);

    // 3: write then read back
    do_reset();
    drive(2'b10, 2'b10, 2'b00, 10'd0, 10'd7, 8'h00, 8'h3C);
    @(negedge clk);
    chk("t3_we", 32'(oRamWriteEnable), 32'h1);
    chk("t3_waddr", 32'(oRamWriteAddress), 32'd7);
    chk("t3_din", 32'(oRamDataIn), 32'h3C);
    step();
    drive(2'b01, 2'b00, 2'b00, 10'd7, 10'd0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t3_we_off", 32'(oRamWriteEnable), 32'h0);
    step(); idle();
    @(negedge clk);
    chk("t3_valid", 32'(oRdValid), 32'h1);
    chk("t3_data", 32'(oRdData), 32'h3C);

    // 4: port 1 lock bounded by LOCK_MAX
    do_reset();
    drive(2'b11, 2'b00, 2'b10, 10'd1, 10'd2, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      gs[i] = oGrant;
      step();
    end
    idle();
    chk("t4_grants", 32'({gs[0], gs[1], gs[2], gs[3], gs[4], gs[5]}), 32'b011010101001);

    // 5: lock owner drops request
    do_reset();
    drive(2'b11, 2'b00, 2'b01, 10'd3, 10'd4, 8'h00, 8'h00);
    @(negedge clk); gs[0] = oGrant;
    step();
    @(negedge clk); gs[1] = oGrant;
    step();
    drive(2'b10, 2'b00, 2'b00, 10'd3, 10'd4, 8'h00, 8'h00);
    @(negedge clk); gs[2] = oGrant;
    step(); idle();
    chk("t5_grants", 32'({gs[0], gs[1], gs[2]}), 32'b010110);

    // 6: reset with a read in flight
    do_reset();
    drive(2'b01, 2'b00, 2'b00, 10'd5, 10'd0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t6_grant", 32'(oGrant), 32'h1);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    drive(2'b11, 2'b11, 2'b00, 10'd9, 10'd9, 8'hFF, 8'hFF);
    @(negedge clk);
    chk("t6_rst_out", 32'({oGrant, oRdValid, oRamWriteEnable, oRamReadAddress, oRamDataIn}), 32'h0);
    step();
    rst_n = 1'b1;
    drive(2'b11, 2'b00, 2'b00, 10'd5, 10'd6, 8'h00, 8'h00);
    @(negedge clk);
    chk("t6_first", 32'(oGrant), 32'h1);
    chk("t6_novalid", 32'(oRdValid), 32'h0);
    step(); idle();
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
